det_seq: RTL

Sequential, parametrised determinant engine for the matrix coprocessor. It is the successor to the fixed-size combinational cofactor-expansion determinant units and is sized by N (2..5) and element width W. It evaluates the Leibniz sum over all N! permutations, generating them with Heap's algorithm and using one multiplier step per cycle. Exact arithmetic runs in a wide accumulator. The block returns a W-bit result with an overflow flag through a start/done handshake.

---
 rtl/det_seq_if.sv | 22 ++
 rtl/det_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/det_seq_if.sv
// det_seq_if -- start/done handshake bundle for the sequential determinant engine.
//   start  : request, taken only while the engine is idle
//   matrix : N*N signed W-bit elements, row-major, element (0,0) in the MSBs
//   busy   : operation in progress
//   done   : one-cycle result strobe; det/ovf valid in that cycle and held after
//   det    : W-bit signed determinant (wrapped, or saturated when configured)
//   ovf    : exact determinant does not fit in W signed bits
// master drives requests, slave is the engine.
interface det_seq_if #(
  parameter int N = 5,
  parameter int W = 8
);
  logic                    start;
  logic [N*N*W-1:0]        matrix;
  logic                    busy;
  logic                    done;
  logic signed [W-1:0]     det;
  logic                    ovf;

  modport master (output start, matrix, input busy, done, det, ovf);
  modport slave  (input start, matrix, output busy, done, det, ovf);
endinterface

// File: rtl/det_seq.sv
// det_seq -- sequential Leibniz determinant engine.
// Walks all N! permutations with iterative Heap's algorithm; each term is
// built with one multiply per cycle (MUL), added/subtracted into a wide exact
// accumulator (ACC), then the Heap loop advances one iteration per cycle (NEXT).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : det_seq_if.slave (start, matrix, busy, done, det, ovf)
// Parameters: N matrix order (2..5), W signed element/result width.
// Build option: define DET_SEQ_SAT_EN to saturate det on overflow instead of
// returning the two's-complement wrap of the exact value.
module det_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst,
  det_seq_if.slave bus
);
  localparam int KW = $clog2(N);      // permutation entries, k, c[] values
  localparam int IW = $clog2(N + 1);  // Heap index i, reaches N
  localparam int PW = N * W;          // exact product of N elements
  localparam int AW = N * W + 7;      // exact sum of up to 120 terms
  localparam int MW = N * N * W;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_NEXT} state_t;

  state_t                   state_q, state_d;
  logic [MW-1:0]            mat_q, mat_d;
  logic [N-1:0][KW-1:0]     p_q, p_d;     // current permutation
  logic [N-1:0][KW-1:0]     c_q, c_d;     // Heap counters
  logic                     sign_q, sign_d;  // 1 = odd permutation
  logic [KW-1:0]            k_q, k_d;
  logic [IW-1:0]            i_q, i_d;
  logic signed [PW-1:0]     prod_q, prod_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [W-1:0]      det_q, det_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;

  // ---------------------------------------------------------------- decode
  logic [KW-1:0]        c_cur;     // c[i]
  logic [KW-1:0]        p_k;       // p[k]
  logic [KW-1:0]        swp_idx;   // partner of p[i] in the Heap swap
  logic [KW-1:0]        p_i_val, p_s_val;
  logic signed [W-1:0]  elem;      // M[k][p[k]]
  logic                 heap_swap, heap_last, mul_last, acc_fits;
  logic signed [PW-1:0] mul_src, elem_x;
  logic signed [AW-1:0] prod_x;
  logic signed [W-1:0]  det_res;

  always_comb begin
    c_cur   = '0;
    p_i_val = '0;
    p_k     = '0;
    for (int j = 0; j < N; j++) begin
      if (IW'(j) == i_q) begin
        c_cur   = c_q[j];
        p_i_val = p_q[j];
      end
      if (KW'(j) == k_q) p_k = p_q[j];
    end
    // odd i swaps with p[c[i]], even i with p[0]
    swp_idx = i_q[0] ? c_cur : '0;
    p_s_val = '0;
    for (int j = 0; j < N; j++)
      if (KW'(j) == swp_idx) p_s_val = p_q[j];
    elem = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (KW'(r) == k_q && KW'(c) == p_k)
          elem = mat_q[(N*N-1-(r*N+c))*W +: W];
  end

  assign heap_swap = (IW'(c_cur) < i_q);
  assign heap_last = (i_q == IW'(N - 1));
  assign mul_last  = (k_q == KW'(N - 1));
  assign elem_x    = {{(PW-W){elem[W-1]}}, elem};
  assign mul_src   = (k_q == '0) ? PW'(1) : prod_q;
  assign prod_x    = {{(AW-PW){prod_q[PW-1]}}, prod_q};
  // value fits W signed bits iff all bits from W-1 upward agree
  assign acc_fits  = (&acc_q[AW-1:W-1]) | ~(|acc_q[AW-1:W-1]);

`ifdef DET_SEQ_SAT_EN
  always_comb begin
    det_res = acc_q[W-1:0];
    if (!acc_fits)
      det_res = acc_q[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign det_res = acc_q[W-1:0];
`endif

  // -------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      p_q     <= '0;
      c_q     <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
      i_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      det_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      p_q     <= p_d;
      c_q     <= c_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
      i_q     <= i_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      det_q   <= det_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_MUL;
      S_MUL:  if (mul_last)  state_d = S_ACC;
      S_ACC:  state_d = S_NEXT;
      S_NEXT: begin
        if (heap_swap)      state_d = S_MUL;
        else if (heap_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------ datapath / outputs
  always_comb begin
    mat_d  = mat_q;
    p_d    = p_q;
    c_d    = c_q;
    sign_d = sign_q;
    k_d    = k_q;
    i_d    = i_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    det_d  = det_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mat_d  = bus.matrix;
          for (int j = 0; j < N; j++) p_d[j] = KW'(j);
          c_d    = '0;
          sign_d = 1'b0;
          acc_d  = '0;
          k_d    = '0;
          i_d    = IW'(1);
        end
      end
      S_MUL: begin
        // low PW bits of the product are exact: |prod| < 2^(PW-1)
        prod_d = mul_src * elem_x;
        k_d    = mul_last ? '0 : k_q + KW'(1);
      end
      S_ACC: begin
        acc_d = sign_q ? acc_q - prod_x : acc_q + prod_x;
        i_d   = IW'(1);
      end
      S_NEXT: begin
        if (heap_swap) begin
          for (int j = 0; j < N; j++) begin
            if (KW'(j) == swp_idx) p_d[j] = p_i_val;
            if (IW'(j) == i_q) begin
              p_d[j] = p_s_val;
              c_d[j] = c_q[j] + KW'(1);
            end
          end
          sign_d = ~sign_q;
          i_d    = IW'(1);
          k_d    = '0;
        end else begin
          for (int j = 0; j < N; j++)
            if (IW'(j) == i_q) c_d[j] = '0;
          i_d = i_q + IW'(1);
          if (heap_last) begin
            det_d  = det_res;
            ovf_d  = ~acc_fits;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.det  = det_q;
  assign bus.ovf  = ovf_q;
endmodule
